cfg_bus_arbiter: RTL and testbench

- Shares the 4-bit-address / 14-bit-data configuration bus between several configuration sources, e.g. the command manager and a power-on default loader.
- Uses round-robin arbitration.
- Drives c_valid/c_addr/c_data to all configured slaves (clock divider, UART, VGA) and waits for the AND of their c_ready.
- Acknowledges each requester and reports bus timeouts to the LED error path.

---
 rtl/cfg_bus_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_cfg_bus_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cfg_bus_arbiter
//
// Shares one configuration write bus (address + data) between several
// configuration sources. Requesters are served round-robin; the granted
// write is held on c_valid/c_addr/c_data until every slave raises its
// c_ready, after which the requester receives a one-cycle req_ack.
//
// Optional feature macro: CFG_ARB_TIMEOUT_EN
//   defined   : an 8-bit timeout counter aborts a write after TIMEOUT cycles
//               of c_valid, acking it with req_err=1 and pulsing err_valid
//               with err_code = {2'b11, granted index}.
//   undefined : a write waits indefinitely for the slaves; req_err,
//               err_valid and err_code are tied low and TIMEOUT is unused.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-requester write request, held until its req_ack
//   req_addr   : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   : packed data, requester i at [i*DATA_W +: DATA_W]
//   req_ack    : one-cycle completion pulse to the granted requester
//   req_err    : qualifies req_ack; 1 = the write timed out
//   c_valid    : configuration bus valid
//   c_addr     : configuration bus address, stable while c_valid
//   c_data     : configuration bus data, stable while c_valid
//   c_ready    : per-slave accept; a write completes on &c_ready
//   busy       : high whenever the arbiter is not idle
//   err_valid  : one-cycle timeout pulse
//   err_code   : {2'b11, granted index} during err_valid, else 0
// ---------------------------------------------------------------------------
module cfg_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int NUM_SLV = 3,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      req_err,
  output logic                      c_valid,
  output logic [ADDR_W-1:0]         c_addr,
  output logic [DATA_W-1:0]         c_data,
  input  logic [NUM_SLV-1:0]        c_ready,
  output logic                      busy,
  output logic                      err_valid,
  output logic [3:0]                err_code
);

  localparam logic [2:0] NumReq3     = 3'(NUM_REQ);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

`ifdef CFG_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2, ERR = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_e;
`endif

  state_e              state_q;
  logic [1:0]          rrPtr_q;
  logic [1:0]          grant_q;
  logic                c_valid_q;
  logic [ADDR_W-1:0]   c_addr_q;
  logic [DATA_W-1:0]   c_data_q;
  logic [NUM_REQ-1:0]  req_ack_q;
  logic                busy_q;

`ifdef CFG_ARB_TIMEOUT_EN
  logic [7:0]          timeoutCnt_q;
  logic                req_err_q;
  logic                err_valid_q;
  logic [3:0]          err_code_q;
`endif

  logic [2*NUM_REQ-1:0] reqTwice;
  logic [NUM_REQ-1:0]   reqRot;
  logic [3:0]           reqRot4;
  logic                 grantFound;
  logic [1:0]           grantOff;
  logic [2:0]           grantSum;
  logic [1:0]           grant_d;
  logic [ADDR_W-1:0]    selAddr;
  logic [DATA_W-1:0]    selData;
  logic [2:0]           ptrSum;
  logic [1:0]           rrPtr_d;
  logic [NUM_REQ-1:0]   ackVec;

  // Round-robin search: rotate the request vector so rr_ptr lands on bit 0,
  // take the lowest set bit, then map the offset back to a requester index.
  // The if-chain runs highest bit first so the lowest set bit wins.
  always_comb begin
    reqTwice   = {req_valid, req_valid};
    reqRot     = NUM_REQ'(reqTwice >> rrPtr_q);
    reqRot4    = 4'(reqRot);
    grantFound = |reqRot;
    grantOff   = 2'd0;
    if (reqRot4[3]) grantOff = 2'd3;
    if (reqRot4[2]) grantOff = 2'd2;
    if (reqRot4[1]) grantOff = 2'd1;
    if (reqRot4[0]) grantOff = 2'd0;
    grantSum = {1'b0, rrPtr_q} + {1'b0, grantOff};
    grant_d  = (grantSum >= NumReq3) ? 2'(grantSum - NumReq3) : grantSum[1:0];
    selAddr  = ADDR_W'(req_addr >> (int'(grant_d) * ADDR_W));
    selData  = DATA_W'(req_data >> (int'(grant_d) * DATA_W));
    ptrSum   = {1'b0, grant_q} + 3'd1;
    rrPtr_d  = (ptrSum == NumReq3) ? 2'd0 : ptrSum[1:0];
    ackVec   = NUM_REQ'(1) << grant_q;
  end

  // Every output register is loaded with the value belonging to the state
  // being entered, so outputs change on the same edge as the state.
  // rr_ptr moves when a write finishes (entering DONE or ERR).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rrPtr_q      <= '0;
      grant_q      <= '0;
      c_valid_q    <= 1'b0;
      c_addr_q     <= '0;
      c_data_q     <= '0;
      req_ack_q    <= '0;
      busy_q       <= 1'b0;
`ifdef CFG_ARB_TIMEOUT_EN
      timeoutCnt_q <= '0;
      req_err_q    <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
`endif
    end else begin
      req_ack_q   <= '0;
`ifdef CFG_ARB_TIMEOUT_EN
      req_err_q   <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (grantFound) begin
            state_q      <= ISSUE;
            grant_q      <= grant_d;
            c_addr_q     <= selAddr;
            c_data_q     <= selData;
            c_valid_q    <= 1'b1;
            busy_q       <= 1'b1;
`ifdef CFG_ARB_TIMEOUT_EN
            timeoutCnt_q <= '0;
`endif
          end
        end
        ISSUE: begin
          if (&c_ready) begin
            state_q   <= DONE;
            c_valid_q <= 1'b0;
            req_ack_q <= ackVec;
            rrPtr_q   <= rrPtr_d;
          end
`ifdef CFG_ARB_TIMEOUT_EN
          else if (timeoutCnt_q == TimeoutLast) begin
            state_q     <= ERR;
            c_valid_q   <= 1'b0;
            req_ack_q   <= ackVec;
            req_err_q   <= 1'b1;
            err_valid_q <= 1'b1;
            err_code_q  <= {2'b11, grant_q};
            rrPtr_q     <= rrPtr_d;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 8'd1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
`ifdef CFG_ARB_TIMEOUT_EN
        ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
`endif
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          c_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign c_valid = c_valid_q;
  assign c_addr  = c_addr_q;
  assign c_data  = c_data_q;
  assign req_ack = req_ack_q;
  assign busy    = busy_q;

`ifdef CFG_ARB_TIMEOUT_EN
  assign req_err   = req_err_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
`else
  assign req_err   = 1'b0;
  assign err_valid = 1'b0;
  assign err_code  = 4'd0;

  // TIMEOUT has no function without the counter.
  logic unusedTimeout;
  assign unusedTimeout = ^TimeoutLast;
`endif

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cfg_bus_arbiter
//
// Directed bench for cfg_bus_arbiter. The stimulus process queues the
// expected outcome of every write it issues; an independent monitor watches
// the bus at each falling clock edge, measures c_valid length and latched
// address/data, and pops the queue whenever req_ack pulses.
// ---------------------------------------------------------------------------
module tb_cfg_bus_arbiter;

  localparam int NREQ = 2;
  localparam int NSLV = 3;
  localparam int AW   = 4;
  localparam int DW   = 14;
`ifdef CFG_ARB_TIMEOUT_EN
  localparam int TOUT        = 4;
  localparam int PARTIAL_LEN = 3;
  localparam int STALL       = 2;
`else
  localparam int TOUT        = 255;
  localparam int PARTIAL_LEN = 11;
  localparam int STALL       = 1000;
`endif

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ*DW-1:0]     req_data;
  logic [NREQ-1:0]        req_ack;
  logic                   req_err;
  logic                   c_valid;
  logic [AW-1:0]          c_addr;
  logic [DW-1:0]          c_data;
  logic [NSLV-1:0]        c_ready;
  logic                   busy;
  logic                   err_valid;
  logic [3:0]             err_code;

  typedef struct {
    int         idx;
    logic [3:0] addr;
    logic [13:0] data;
    bit         err;
    int         len;
    int         gap;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  cfg_bus_arbiter #(
    .NUM_REQ (NREQ),
    .NUM_SLV (NSLV),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .req_err   (req_err),
    .c_valid   (c_valid),
    .c_addr    (c_addr),
    .c_data    (c_data),
    .c_ready   (c_ready),
    .busy      (busy),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failWait(input string name, input int limit);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=no event required=event within %0d cycles at %0t", name, limit, $time);
  endtask

  task automatic resetChecks();
    checkOutput("rstValid",    32'(c_valid),   32'd0);
    checkOutput("rstAddr",     32'(c_addr),    32'd0);
    checkOutput("rstData",     32'(c_data),    32'd0);
    checkOutput("rstAck",      32'(req_ack),   32'd0);
    checkOutput("rstReqErr",   32'(req_err),   32'd0);
    checkOutput("rstBusy",     32'(busy),      32'd0);
    checkOutput("rstErrValid", 32'(err_valid), 32'd0);
    checkOutput("rstErrCode",  32'(err_code),  32'd0);
  endtask

  task automatic setSlot(input int idx, input logic [3:0] addr, input logic [13:0] data);
    if (idx == 0) begin
      req_addr[3:0]  = addr;
      req_data[13:0] = data;
    end else begin
      req_addr[7:4]   = addr;
      req_data[27:14] = data;
    end
  endtask

  task automatic setValid(input int idx, input logic v);
    if (idx == 0) req_valid[0] = v;
    else          req_valid[1] = v;
  endtask

  // One write from a single requester. validLen is the number of cycles
  // c_valid must stay high; holdReady is the slave ready pattern presented
  // until the write should be accepted. For a timeout write no ready is given.
  task automatic applyStimulus(input int idx, input logic [3:0] addr, input logic [13:0] data,
                               input int validLen, input logic [2:0] holdReady, input bit expectErr);
    bit seen;
    expQ.push_back('{idx, addr, data, expectErr, validLen, 0});
    setSlot(idx, addr, data);
    setValid(idx, 1'b1);
    c_ready = holdReady;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (c_valid) seen = 1;
    end
    if (!seen) failWait("grantWait", 10);
    setSlot(idx, ~addr, ~data);
    if (!expectErr) begin
      for (int i = 1; i < validLen; i++) begin
        @(posedge clk); #1;
      end
      c_ready = 3'b111;
    end
    seen = 0;
    for (int i = 0; i < validLen + 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (req_ack != '0) seen = 1;
    end
    if (!seen) failWait("ackWait", validLen + 10);
    setValid(idx, 1'b0);
    c_ready = 3'b000;
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    bit         inTxn;
    bit         ackPrev;
    int         len;
    int         cyc;
    int         lastAck;
    logic [3:0] capAddr;
    logic [13:0] capData;
    exp_t       e;
    inTxn = 0; ackPrev = 0; len = 0; cyc = 0; lastAck = 0;
    capAddr = '0; capData = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inTxn = 0;
        ackPrev = 0;
        len = 0;
      end else begin
        cyc++;
        if (ackPrev) begin
          checkOutput("busyAfterAck", 32'(busy), 32'd0);
          checkOutput("ackOneCycle", 32'(req_ack), 32'd0);
        end
        ackPrev = 0;
        if (c_valid) begin
          if (!inTxn) begin
            inTxn = 1;
            len = 0;
            capAddr = c_addr;
            capData = c_data;
          end else begin
            checkOutput("addrStable", 32'(c_addr), 32'(capAddr));
            checkOutput("dataStable", 32'(c_data), 32'(capData));
          end
          len++;
          checkOutput("busyDuringValid", 32'(busy), 32'd1);
        end
        if (req_ack != '0) begin
          ackPrev = 1;
          if (expQ.size() == 0) begin
            checkOutput("unexpectedAck", 32'(req_ack), 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("ackVector",  32'(req_ack),   32'd1 << e.idx);
            checkOutput("reqErr",     32'(req_err),   32'(e.err));
            checkOutput("busAddr",    32'(capAddr),   32'(e.addr));
            checkOutput("busData",    32'(capData),   32'(e.data));
            checkOutput("validCycles", 32'(inTxn ? len : 0), 32'(e.len));
            checkOutput("validLowAtAck", 32'(c_valid), 32'd0);
            checkOutput("busyAtAck",  32'(busy),      32'd1);
            checkOutput("errValid",   32'(err_valid), 32'(e.err));
            checkOutput("errCode",    32'(err_code),  e.err ? 32'(12 + e.idx) : 32'd0);
            if (e.gap != 0) checkOutput("ackGap", 32'(cyc - lastAck), 32'(e.gap));
          end
          lastAck = cyc;
          inTxn = 0;
        end else begin
          checkOutput("errValidIdle", 32'(err_valid), 32'd0);
        end
      end
    end
  end

  initial begin : stimulus
    int  acks;
    bit  seen;
    rst_n     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    c_ready   = '0;
    #1 rst_n = 1'b0;
    #1 resetChecks();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write, ready on the second ISSUE cycle.
    applyStimulus(0, 4'h3, 14'h00A5, 2, 3'b000, 1'b0);
    // Ready on the very first ISSUE edge, all-ones boundary values.
    applyStimulus(1, 4'hF, 14'h3FFF, 1, 3'b000, 1'b0);

    // Ready high while idle must not start anything.
    c_ready = 3'b111;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idleReadyValid", 32'(c_valid), 32'd0);
    checkOutput("idleReadyBusy",  32'(busy),    32'd0);
    applyStimulus(0, 4'h0, 14'h0000, 1, 3'b111, 1'b0);

    // Partial ready: one slave holds off.
    applyStimulus(1, 4'h9, 14'h1234, PARTIAL_LEN, 3'b011, 1'b0);

`ifdef CFG_ARB_TIMEOUT_EN
    applyStimulus(0, 4'h6, 14'h2AAA, TOUT, 3'b000, 1'b1);
`endif

    // Contention straight after reset: strict 0,1,0,1 alternation.
    rst_n = 1'b0;
    #1 resetChecks();
    @(posedge clk); #1;
    rst_n = 1'b1;
    setSlot(0, 4'h5, 14'h0111);
    setSlot(1, 4'hA, 14'h2222);
    expQ.push_back('{0, 4'h5, 14'h0111, 1'b0, 1, 0});
    expQ.push_back('{1, 4'hA, 14'h2222, 1'b0, 1, 3});
    expQ.push_back('{0, 4'h5, 14'h0111, 1'b0, 1, 3});
    expQ.push_back('{1, 4'hA, 14'h2222, 1'b0, 1, 3});
    c_ready   = 3'b111;
    req_valid = 2'b11;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(posedge clk); #1;
      if (req_ack != '0) acks++;
    end
    if (acks < 4) failWait("contentionAcks", 40);
    req_valid = '0;
    c_ready   = '0;
    @(posedge clk); #1;

    // Leave rr_ptr pointing at requester 1.
    applyStimulus(0, 4'h7, 14'h0155, 1, 3'b000, 1'b0);

    // Both request, slaves never ready: requester 1 holds the bus.
    setSlot(0, 4'hB, 14'h0BEE);
    setSlot(1, 4'hD, 14'h1DDD);
    req_valid = 2'b11;
    repeat (STALL) @(posedge clk);
    #1;
    checkOutput("stallValid", 32'(c_valid), 32'd1);
    checkOutput("stallBusy",  32'(busy),    32'd1);
    checkOutput("stallAddr",  32'(c_addr),  32'hD);
    checkOutput("stallData",  32'(c_data),  32'h1DDD);

    // Reset mid-ISSUE: no ack for the dropped write, then requester 0 first.
    rst_n = 1'b0;
    #1 resetChecks();
    c_ready = 3'b111;
    expQ.push_back('{0, 4'hB, 14'h0BEE, 1'b0, 1, 0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (req_ack != '0) seen = 1;
    end
    if (!seen) failWait("regrantAck", 10);
    req_valid = '0;
    c_ready   = '0;
    repeat (3) @(posedge clk);
    #1;

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
